i2c_reg_reader: RTL and testbench
=================================

# i2c_reg_reader

Autonomous I2C register-read sequencer that sits directly upstream of the `i2c` peripheral and drives its 4-bit register bus in place of the CPU. On a single `start` pulse it programs the bit-period divider, then performs START, device-address+W, register-address byte, repeated START, device-address+R, 1–4 read bytes and STOP. It returns the assembled read word, with NACK and timeout status. It lets sensor-polling logic fetch device registers without CPU involvement.

## Interface
- `TIMEOUT_CYCLES`, default 1048576: maximum cycles spent waiting on any single peripheral step before abort.
- `clk` in 1: rising-edge clock, shared with the `i2c` peripheral.
- `reset` in 1: reset, synchronous, active-low; one clock; all state is cleared on a `clk` edge while `reset`==0.
- `start` in 1: request pulse, sampled only in IDLE.
- `dev_addr` in 7: 7-bit target address, captured on accepted `start`.
- `reg_addr` in 8: target register index, captured on accepted `start`.
- `nbytes` in 2: read length; 1–3 literal, 0 means 4.
- `clk_div` in 16: value written to the peripheral speed register.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `nack` out 1: sticky; the last transaction had an address or register byte NACKed.
- `timeout` out 1: sticky; the last transaction was aborted by the watchdog.
- `rdata` out 32: read result, big-endian, right-aligned; the first byte received is most significant.
- `bus_addr` out 4: peripheral register select.
- `bus_wdata` out 32: peripheral write data.
- `bus_we` out 1: peripheral write strobe, one cycle per write.
- `bus_rdata` in 32: peripheral combinational read data for `bus_addr`.

## Operation
- Peripheral register map, fixed:
  - Speed register: addr 10, `[31:16]`.
  - Flag register: addr 13. Write `[14]` for start, `[12]` for continue, `[11]` for stop. Read `[15]` for ready and `[13]` for ack.
  - Data register: addr 14, `[23:16]`.
- Command words:
  - START: 32'h0000_4000.
  - CONT: 32'h0000_1000.
  - STOP: 32'h0000_0800.
- All bus outputs are registered. Outside write cycles, `bus_addr`=13 so that ready and ack can be polled.
- Step primitive EXEC(cmd):
  - Write cmd to addr 13.
  - WAIT_LO: wait until ready==0.
  - WAIT_HI: wait until ready==1.
  - The watchdog counter clears at each EXEC entry.
- FSM states: IDLE, SPEED, LD_AW, ST1, LD_REG, CONT_REG, LD_AR, ST2, RD_CONT, RD_CAP, STOP, FIN.
  - IDLE → SPEED on `start`. Capture the inputs, clear `nack`, `timeout` and `rdata`, and set the byte counter to N (1–4).
  - SPEED: write {`clk_div`,16'h0} to addr 10 → LD_AW.
  - LD_AW: write {8'h0,`dev_addr`,1'b0,16'h0} to addr 14 → ST1.
  - ST1: EXEC(START). On ready, check ack. If ack==0, set `nack` → FIN; the peripheral stops the bus itself and no STOP is issued. Otherwise → LD_REG.
  - LD_REG: write `reg_addr` to the data register → CONT_REG.
  - CONT_REG: EXEC(CONT), then the same ack check → LD_AR.
  - LD_AR: write {`dev_addr`,1'b1} to the data register → ST2.
  - ST2: EXEC(START) for the repeated start, then the ack check → RD_CONT.
  - RD_CONT: EXEC(CONT) → RD_CAP.
  - RD_CAP: set `bus_addr`=14 for one cycle and capture `rdata` <= {`rdata`[23:0], `bus_rdata`[23:16]}. Decrement the counter. If the counter is 0 → STOP, else → RD_CONT. The master ACKs every read byte, including the last.
  - STOP: EXEC(STOP) → FIN.
  - FIN: pulse `done` → IDLE.
- Watchdog: if any WAIT_LO/WAIT_HI lasts `TIMEOUT_CYCLES` cycles, set `timeout`, write STOP once, then go → FIN without waiting for ready.
- `start` while `busy`: ignored; the captured inputs are unchanged.

## Timing
- Reset values:
  - `busy`, `done`, `nack`, `timeout`, `bus_we`: 0.
  - `rdata`, `bus_wdata`: 0.
  - `bus_addr`: 13.
  - FSM state: IDLE.
- Reset mid-transaction: return to IDLE next edge, with no further bus writes. The peripheral is not reset by this block.
- `busy` rises 1 cycle after the `start` edge. The SPEED write follows on the next cycle.
- WAIT_LO is required because ready falls only 2 cycles after a command write. Sampling ready before it falls would complete the step falsely.
- `done` is asserted exactly 1 cycle after the final observed ready rise, or after the ack check that detects a NACK. `busy` falls in the same cycle `done` pulses.
- `rdata`, `nack` and `timeout` are stable from the `done` cycle until the next accepted `start`.

## Test plan
- Read 2 bytes: `dev_addr`=7'h48, `reg_addr`=8'h00, `nbytes`=2, `clk_div`=16'd20, with a slave model answering 8'h1A, 8'h80.
  - Required bus writes, in order: addr10=32'h0014_0000; addr14=32'h0090_0000; START; addr14=32'h0000_0000; CONT; addr14=32'h0091_0000; START; CONT; CONT; STOP.
  - Required result: `rdata`=32'h0000_1A80, `nack`=0, one `done` pulse.
- `nbytes`=0 against a slave returning DE AD BE EF → `rdata`=32'hDEADBEEF after 4 RD_CAP cycles.
- Address NACK: the slave ignores address 7'h50.
  - `nack`=1, `rdata`=0, `done` pulses.
  - No CONT or STOP is written after the first START.
- Stuck bus: the peripheral model holds ready=1 forever with `TIMEOUT_CYCLES`=64.
  - `timeout`=1 at 64 cycles after the first EXEC wait.
  - Exactly one STOP is written, then `done` pulses.
- `start` pulsed mid-read with a different `dev_addr` → ignored; the original transaction completes with the original address.
- `reset` driven low during RD_CONT → next edge: `busy`=0, `bus_we`=0, `bus_addr`=13; a new `start` after release runs a clean transaction.

Source files
------------

// File: rtl/i2c_reg_reader.sv
// Purpose: autonomous I2C register-read sequencer driving the i2c peripheral's register bus.
// Latency: one bus action per cycle; each command waits for the peripheral ready handshake.
// Backpressure: a start request is taken only in IDLE; peripheral steps are bounded by a watchdog.
module i2c_reg_reader #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  input  logic [1:0]  nbytes,
  input  logic [15:0] clk_div,
  output logic        busy,
  output logic        done,
  output logic        nack,
  output logic        timeout,
  output logic [31:0] rdata,
  output logic [3:0]  bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  input  logic [31:0] bus_rdata
);

  localparam logic [3:0]  ADDR_SPEED = 4'd10;
  localparam logic [3:0]  ADDR_FLAG  = 4'd13;
  localparam logic [3:0]  ADDR_DATA  = 4'd14;
  localparam logic [31:0] CMD_START  = 32'h0000_4000;
  localparam logic [31:0] CMD_CONT   = 32'h0000_1000;
  localparam logic [31:0] CMD_STOP   = 32'h0000_0800;

  // Watchdog wide enough to hold TIMEOUT_CYCLES itself.
  localparam int             WDW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, SPEED, LD_AW, ST1, LD_REG, CONT_REG, LD_AR, ST2, RD_CONT, RD_CAP, STOP, FIN
  } state_t;

  // Sub-phases of one peripheral command: write it, see ready drop, see ready return.
  typedef enum logic [1:0] {
    PH_WR, PH_LO, PH_HI
  } phase_t;

  state_t         state;
  phase_t         phase;
  logic [WDW-1:0] wdog;
  logic [2:0]     cnt;
  logic [6:0]     dev_q;
  logic [7:0]     reg_q;
  logic [15:0]    div_q;
  logic [31:0]    exec_cmd;
  logic           ack_check;
  logic           ready;
  logic           ack;
  logic           unused_rdata;

  assign ready        = bus_rdata[15];
  assign ack          = bus_rdata[13];
  assign unused_rdata = ^{bus_rdata[31:24], bus_rdata[14], bus_rdata[12:0]};

  // Address and register-byte phases are the only ones whose ack matters.
  assign ack_check = (state == ST1) || (state == CONT_REG) || (state == ST2);

  // Command word issued by whichever command-executing state is active.
  always_comb begin
    exec_cmd = CMD_CONT;
    case (state)
      ST1, ST2: exec_cmd = CMD_START;
      STOP:     exec_cmd = CMD_STOP;
      default:  exec_cmd = CMD_CONT;
    endcase
  end

  // Sequencer: all bus outputs and status are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= PH_WR;
      wdog      <= '0;
      cnt       <= '0;
      dev_q     <= '0;
      reg_q     <= '0;
      div_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      timeout   <= 1'b0;
      rdata     <= '0;
      bus_addr  <= ADDR_FLAG;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
    end else begin
      // Idle bus default: point at the flag register so ready/ack can be polled.
      bus_we   <= 1'b0;
      bus_addr <= ADDR_FLAG;
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            dev_q   <= dev_addr;
            reg_q   <= reg_addr;
            div_q   <= clk_div;
            cnt     <= (nbytes == 2'd0) ? 3'd4 : {1'b0, nbytes};
            nack    <= 1'b0;
            timeout <= 1'b0;
            rdata   <= '0;
            busy    <= 1'b1;
            state   <= SPEED;
          end
        end

        SPEED: begin
          bus_we    <= 1'b1;
          bus_addr  <= ADDR_SPEED;
          bus_wdata <= {div_q, 16'h0000};
          state     <= LD_AW;
        end

        LD_AW: begin
          bus_we    <= 1'b1;
          bus_addr  <= ADDR_DATA;
          bus_wdata <= {8'h00, dev_q, 1'b0, 16'h0000};
          state     <= ST1;
        end

        LD_REG: begin
          bus_we    <= 1'b1;
          bus_addr  <= ADDR_DATA;
          bus_wdata <= {8'h00, reg_q, 16'h0000};
          state     <= CONT_REG;
        end

        LD_AR: begin
          bus_we    <= 1'b1;
          bus_addr  <= ADDR_DATA;
          bus_wdata <= {8'h00, dev_q, 1'b1, 16'h0000};
          state     <= ST2;
        end

        ST1, CONT_REG, ST2, RD_CONT, STOP: begin
          if (phase == PH_WR) begin
            bus_we    <= 1'b1;
            bus_addr  <= ADDR_FLAG;
            bus_wdata <= exec_cmd;
            wdog      <= '0;
            phase     <= PH_LO;
          end else if (phase == PH_LO && !ready) begin
            // Ready only drops a couple of cycles after the write; wait for it first.
            phase <= PH_HI;
            wdog  <= wdog + WDW'(1);
          end else if (phase == PH_HI && ready) begin
            phase <= PH_WR;
            if (ack_check && !ack) begin
              // The peripheral releases the bus on its own after a NACK.
              nack  <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              case (state)
                ST1:      state <= LD_REG;
                CONT_REG: state <= LD_AR;
                ST2:      state <= RD_CONT;
                RD_CONT: begin
                  bus_addr <= ADDR_DATA;
                  state    <= RD_CAP;
                end
                default: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
                end
              endcase
            end
          end else if (wdog >= WD_LAST) begin
            // Watchdog abort: one STOP, then finish without waiting on ready.
            timeout   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= ADDR_FLAG;
            bus_wdata <= CMD_STOP;
            phase     <= PH_WR;
            state     <= FIN;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end

        RD_CAP: begin
          rdata <= {rdata[23:0], bus_rdata[23:16]};
          cnt   <= cnt - 3'd1;
          state <= (cnt == 3'd1) ? STOP : RD_CONT;
        end

        FIN: begin
          // Normal and NACK paths arrive with done already raised; the abort path raises it here.
          if (busy) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_reader.sv
// Bench for i2c_reg_reader: peripheral/slave model, transaction-level reference, per-cycle compare.
module tb_i2c_reg_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  dev_addr = '0;
  logic [7:0]  reg_addr = '0;
  logic [1:0]  nbytes = '0;
  logic [15:0] clk_div = '0;
  logic        busy, done, nack, timeout, bus_we;
  logic [31:0] rdata, bus_wdata, bus_rdata;
  logic [3:0]  bus_addr;

  i2c_reg_reader #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .nbytes(nbytes), .clk_div(clk_div), .busy(busy), .done(done), .nack(nack),
    .timeout(timeout), .rdata(rdata), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endfunction

  function automatic void chk_true(input string name, input bit cond);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s got false want true", name);
    end
  endfunction

  // ---------------- peripheral + slave model ----------------
  logic       p_ready = 1'b1;
  logic       p_ack = 1'b0;
  logic [7:0] p_data = 8'h00;
  bit         p_is_read = 1'b0;
  bit         stuck = 1'b0;
  int         p_t = -1;
  int         p_len = 1;
  int         p_rd_idx = 0;
  logic [6:0] slave_addr = 7'h48;
  logic [7:0] sbytes [4];

  assign bus_rdata = (bus_addr == 4'd13) ? {16'h0, p_ready, 1'b0, p_ack, 13'h0} :
                     (bus_addr == 4'd14) ? {8'h00, p_data, 16'h0} : 32'h0;

  always @(negedge clk) begin
    if (bus_we && bus_addr == 4'd14) p_data = bus_wdata[23:16];
    if (bus_we && bus_addr == 4'd13) begin
      p_t   = 0;
      p_len = $urandom_range(1, 6);
      if (bus_wdata[14]) begin
        p_is_read = p_data[0];
        p_ack     = (p_data[7:1] == slave_addr);
        p_rd_idx  = 0;
      end else if (bus_wdata[12]) begin
        if (p_is_read && p_rd_idx < 4) begin
          p_data = sbytes[p_rd_idx];
          p_rd_idx++;
        end
        p_ack = 1'b1;
      end
    end else if (p_t >= 0 && p_t < 1000) begin
      p_t++;
    end
    p_ready = stuck ? 1'b1 : !(p_t >= 2 && p_t < 2 + p_len);
  end

  // ---------------- reference expectations ----------------
  logic [35:0] exp_q[$];
  logic [31:0] exp_rdata = '0;
  logic        exp_nack = 1'b0;
  logic        exp_tmo = 1'b0;
  logic [31:0] hold_rdata = '0;
  logic        hold_nack = 1'b0;
  logic        hold_tmo = 1'b0;

  logic [3:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          ncyc = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  int          tmo_rise_cyc = -1;
  logic        tmo_prev = 1'b0;
  bit          armed = 1'b0;
  logic [35:0] e;

  // Single compare process: every write, every done, every idle cycle.
  always @(negedge clk) begin
    if (armed) begin
      ncyc++;
      if (bus_we) begin
        log_addr.push_back(bus_addr);
        log_data.push_back(bus_wdata);
        log_cyc.push_back(ncyc);
        chk_true("write_expected", exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("bus_write", {bus_addr, bus_wdata}, e);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_busy_low", busy, 1'b0);
        chk("writes_left", exp_q.size(), 0);
        chk("rdata", rdata, exp_rdata);
        chk("nack", nack, exp_nack);
        chk("timeout", timeout, exp_tmo);
        hold_rdata = exp_rdata;
        hold_nack  = exp_nack;
        hold_tmo   = exp_tmo;
      end else if (!busy) begin
        chk("idle_we", bus_we, 1'b0);
        chk("idle_addr", bus_addr, 4'd13);
        chk("idle_rdata", rdata, hold_rdata);
        chk("idle_nack", nack, hold_nack);
        chk("idle_timeout", timeout, hold_tmo);
      end
      if (timeout && !tmo_prev) tmo_rise_cyc = ncyc;
      tmo_prev = timeout;
    end
  end

  task automatic launch(input logic [6:0] dev, input logic [7:0] rg, input logic [1:0] nb,
                        input logic [15:0] div, input bit present, input bit stk);
    int n;
    logic [31:0] r;
    n = (nb == 2'd0) ? 4 : int'(nb);
    stuck = stk;
    slave_addr = present ? dev : (dev ^ 7'h7F);
    exp_q.delete();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    exp_q.push_back({4'd10, div, 16'h0});
    exp_q.push_back({4'd14, 8'h00, dev, 1'b0, 16'h0});
    exp_q.push_back({4'd13, 32'h0000_4000});
    exp_rdata = '0;
    exp_nack  = 1'b0;
    exp_tmo   = 1'b0;
    if (stk) begin
      exp_q.push_back({4'd13, 32'h0000_0800});
      exp_tmo = 1'b1;
    end else if (!present) begin
      exp_nack = 1'b1;
    end else begin
      exp_q.push_back({4'd14, 8'h00, rg, 16'h0});
      exp_q.push_back({4'd13, 32'h0000_1000});
      exp_q.push_back({4'd14, 8'h00, dev, 1'b1, 16'h0});
      exp_q.push_back({4'd13, 32'h0000_4000});
      for (int i = 0; i < n; i++) exp_q.push_back({4'd13, 32'h0000_1000});
      exp_q.push_back({4'd13, 32'h0000_0800});
      r = '0;
      for (int i = 0; i < n; i++) r = {r[23:0], sbytes[i]};
      exp_rdata = r;
    end
    done_base = done_cnt;
    dev_addr = dev;
    reg_addr = rg;
    nbytes   = nb;
    clk_div  = div;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1'b1);
    chk("no_write_before_speed", bus_we, 1'b0);
    @(negedge clk);
    chk("speed_write_next", {bus_we, bus_addr}, {1'b1, 4'd10});
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done_cnt == done_base && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk_true({name, "_done_seen"}, done_cnt != done_base);
    repeat (2) @(negedge clk);
    chk({name, "_one_done"}, done_cnt - done_base, 1);
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (log_addr.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk_true("log_reached", log_addr.size() >= n);
  endtask

  logic [35:0] lit1 [10];
  int stops;

  initial begin
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    lit1 = '{{4'd10, 32'h0014_0000}, {4'd14, 32'h0090_0000}, {4'd13, 32'h0000_4000},
             {4'd14, 32'h0000_0000}, {4'd13, 32'h0000_1000}, {4'd14, 32'h0091_0000},
             {4'd13, 32'h0000_4000}, {4'd13, 32'h0000_1000}, {4'd13, 32'h0000_1000},
             {4'd13, 32'h0000_0800}};

    // Reset state
    @(negedge clk);
    armed = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nack", nack, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_addr", bus_addr, 4'd13);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Two-byte read
    sbytes = '{8'h1A, 8'h80, 8'h00, 8'h00};
    launch(7'h48, 8'h00, 2'd2, 16'd20, 1'b1, 1'b0);
    wait_done("read2");
    chk("read2_rdata_lit", rdata, 32'h0000_1A80);
    chk("read2_nack_lit", nack, 1'b0);
    chk("read2_log_len", log_addr.size(), 10);
    for (int i = 0; i < 10 && i < log_addr.size(); i++)
      chk("read2_log_lit", {log_addr[i], log_data[i]}, lit1[i]);

    // Four-byte read
    sbytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    launch(7'h3C, 8'h7E, 2'd0, 16'd3, 1'b1, 1'b0);
    wait_done("read4");
    chk("read4_rdata_lit", rdata, 32'hDEAD_BEEF);

    // Address NACK
    launch(7'h50, 8'h01, 2'd1, 16'd9, 1'b0, 1'b0);
    wait_done("nack");
    chk("nack_lit", nack, 1'b1);
    chk("nack_rdata_lit", rdata, 32'h0);
    chk("nack_log_len", log_addr.size(), 3);

    // Stuck bus: ready never drops
    launch(7'h48, 8'h05, 2'd1, 16'd4, 1'b1, 1'b1);
    wait_done("stuck");
    stuck = 1'b0;
    chk("stuck_timeout_lit", timeout, 1'b1);
    chk("stuck_log_len", log_addr.size(), 4);
    if (log_cyc.size() >= 3)
      chk("stuck_timeout_delay", tmo_rise_cyc - log_cyc[2], 64);
    stops = 0;
    foreach (log_data[i]) if (log_addr[i] == 4'd13 && log_data[i] == 32'h0000_0800) stops++;
    chk("stuck_one_stop", stops, 1);
    repeat (12) @(negedge clk);

    // Start pulsed mid-read is ignored
    sbytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    launch(7'h48, 8'h22, 2'd0, 16'd7, 1'b1, 1'b0);
    wait_log(9);
    dev_addr = 7'h11;
    reg_addr = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("midstart");
    chk("midstart_rdata_lit", rdata, 32'h1122_3344);
    if (log_data.size() >= 6) chk("midstart_ar_lit", log_data[5], 32'h0091_0000);
    repeat (5) @(negedge clk);
    chk("midstart_no_restart", busy, 1'b0);

    // Reset during RD_CONT
    sbytes = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    launch(7'h48, 8'h10, 2'd3, 16'd5, 1'b1, 1'b0);
    wait_log(8);
    reset = 1'b0;
    exp_q.delete();
    hold_rdata = '0;
    hold_nack  = 1'b0;
    hold_tmo   = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_we", bus_we, 1'b0);
    chk("midrst_addr", bus_addr, 4'd13);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    launch(7'h48, 8'h10, 2'd3, 16'd5, 1'b1, 1'b0);
    wait_done("after_reset");
    chk("after_reset_rdata_lit", rdata, 32'h00A5_5AC3);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      logic [6:0] d;
      logic [7:0] rg;
      logic [1:0] nb;
      logic [15:0] dv;
      bit pres;
      d    = 7'($urandom);
      rg   = 8'($urandom);
      nb   = 2'($urandom);
      dv   = 16'($urandom);
      pres = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) sbytes[i] = 8'($urandom);
      launch(d, rg, nb, dv, pres, 1'b0);
      wait_done("random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
